fp_pipe_ctrl: RTL and testbench

- Sequencing controller for the 5-stage FP add/sub pipeline: extract→align, align→op, op→norm, norm→res, res→out.
- Tracks one valid bit per stage register.
- Generates per-stage enables (i_en) and active-low clears (i_clr) for the stage registers.
- Exposes a valid/ready handshake upstream and downstream, enforces drain-before-mode-switch, and supports a one-cycle pipeline flush.

---
 rtl/fp_pipe_pkg.sv | 19 +
 rtl/fp_pipe_valid_chain.sv | 76 +++++++
 rtl/fp_pipe_ctrl.sv | 128 ++++++++++++
 tb/tb_fp_pipe_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pipe_pkg.sv
// Shared definitions for the FP add/sub pipeline sequencing controller.
// Holds the controller state encoding, the default stage count and the
// precision mode encodings used by the datapath.
package fp_pipe_pkg;

    localparam int unsigned NUM_STAGES_DEF = 5;
    localparam int unsigned CNT_W_DEF      = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    localparam logic MODE_SP = 1'b0;
    localparam logic MODE_DP = 1'b1;

endpackage

// File: rtl/fp_pipe_valid_chain.sv
// Per-stage valid bits and the elastic stall chain for the FP pipeline.
// A stage may load when it is empty or when the stage after it loads; the
// last stage loads when empty or when downstream is ready.
// Optional: FP_PIPE_BUBBLE_GATE_EN gates stage clock enables so that bubbles
// are not written into the datapath registers; valid bits still advance on
// the ungated chain.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_clr          clear all valid bits (pipeline flush)
//   i_accept       an operand enters stage 0 this cycle
//   i_ready        downstream accepts the last stage's result
//   o_v            valid bit per stage (bit 0 = first stage)
//   o_en           ungated stall-chain enables (drive upstream ready)
//   o_stage_en     enables for the datapath stage registers
module fp_pipe_valid_chain #(
    parameter int unsigned NUM_STAGES = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clr,
    input  logic                  i_accept,
    input  logic                  i_ready,
    output logic [NUM_STAGES-1:0] o_v,
    output logic [NUM_STAGES-1:0] o_en,
    output logic [NUM_STAGES-1:0] o_stage_en
);

    logic [NUM_STAGES-1:0] v_q;
    logic [NUM_STAGES-1:0] v_d;
    logic [NUM_STAGES-1:0] en;

    // Stall chain, evaluated from the output stage backwards.
    always_comb begin
        en = '0;
        en[NUM_STAGES-1] = !v_q[NUM_STAGES-1] | i_ready;
        for (int unsigned i = 1; i < NUM_STAGES; i++) begin
            en[NUM_STAGES-1-i] = !v_q[NUM_STAGES-1-i] | en[NUM_STAGES-i];
        end
    end

    // Valid advance uses the ungated chain so bubbles still clear a stage.
    always_comb begin
        v_d = v_q;
        if (i_clr) begin
            v_d = '0;
        end else begin
            if (en[0]) begin
                v_d[0] = i_accept;
            end
            for (int unsigned k = 1; k < NUM_STAGES; k++) begin
                if (en[k]) begin
                    v_d[k] = v_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

`ifdef FP_PIPE_BUBBLE_GATE_EN
    // Only clock a stage when real data is moving into it.
    assign o_stage_en = en & {v_q[NUM_STAGES-2:0], i_accept};
`else
    assign o_stage_en = en;
`endif

    assign o_v  = v_q;
    assign o_en = en;

endmodule

// File: rtl/fp_pipe_ctrl.sv
// Sequencing controller for the 5-stage FP add/sub pipeline.
// Tracks per-stage valid bits, generates stage enables and active-low
// clears, runs the upstream/downstream valid/ready handshake, drains the
// pipeline before a precision-mode switch and supports a one-cycle flush.
// Optional: FP_PIPE_BUBBLE_GATE_EN (see fp_pipe_valid_chain).
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_valid, o_ready  upstream handshake; i_mode is the operand's mode
//   i_flush           discard everything in flight
//   o_valid, i_ready  downstream handshake
//   o_stage_en        per-stage enable, o_stage_clr_n per-stage clear (low)
//   o_mode            mode configured in the datapath
//   o_busy, o_inflight, o_state  status
module fp_pipe_ctrl
    import fp_pipe_pkg::*;
#(
    parameter int unsigned NUM_STAGES = NUM_STAGES_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_mode,
    input  logic                  i_flush,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [NUM_STAGES-1:0] o_stage_en,
    output logic [NUM_STAGES-1:0] o_stage_clr_n,
    output logic                  o_mode,
    output logic                  o_busy,
    output logic [CNT_W-1:0]      o_inflight,
    output logic [1:0]            o_state
);

    state_e                state_q;
    state_e                state_d;
    logic                  mode_q;
    logic                  mode_d;
    logic [CNT_W-1:0]      inflight_q;
    logic [CNT_W-1:0]      inflight_d;

    logic [NUM_STAGES-1:0] v;
    logic [NUM_STAGES-1:0] en;
    logic [NUM_STAGES-1:0] stage_en;
    logic                  mode_ok;
    logic                  ready;
    logic                  accept;
    logic                  adv_out;

    fp_pipe_valid_chain #(
        .NUM_STAGES (NUM_STAGES)
    ) u_valid_chain (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (i_flush),
        .i_accept   (accept),
        .i_ready    (i_ready),
        .o_v        (v),
        .o_en       (en),
        .o_stage_en (stage_en)
    );

    // Upstream handshake; i_ready reaches o_ready combinationally.
    assign mode_ok = (state_q == ST_IDLE) || (i_mode == mode_q);
    assign ready   = !i_rst && en[0] && !i_flush && mode_ok
                     && ((state_q == ST_IDLE) || (state_q == ST_RUN));
    assign accept  = i_valid & ready;
    assign adv_out = v[NUM_STAGES-1] & i_ready;

    // Next state, mode and in-flight count.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(adv_out);
        if (i_flush) begin
            // A result leaving this cycle is dropped from the count too.
            state_d    = ST_FLUSH;
            inflight_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_d = ST_RUN;
                        mode_d  = i_mode;
                    end
                end
                ST_RUN: begin
                    if (i_valid && (i_mode != mode_q)) begin
                        state_d = ST_DRAIN;
                    end else if (inflight_d == '0) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (inflight_d == '0) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_SP;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            inflight_q <= inflight_d;
        end
    end

    assign o_ready       = ready;
    assign o_valid       = v[NUM_STAGES-1];
    assign o_stage_en    = i_rst ? '0 : stage_en;
    assign o_stage_clr_n = (i_rst || (state_q == ST_FLUSH)) ? '0 : '1;
    assign o_mode        = mode_q;
    assign o_busy        = (state_q != ST_IDLE);
    assign o_inflight    = inflight_q;
    assign o_state       = 2'(state_q);

endmodule

// File: tb/tb_fp_pipe_ctrl.sv
// Self-checking bench for fp_pipe_ctrl: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// slot-occupancy model of the pipeline.
module tb_fp_pipe_ctrl;
    import fp_pipe_pkg::*;

    localparam int N = 5;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_valid;
    logic       o_ready;
    logic       i_mode;
    logic       i_flush;
    logic       o_valid;
    logic       i_ready;
    logic [4:0] o_stage_en;
    logic [4:0] o_stage_clr_n;
    logic       o_mode;
    logic       o_busy;
    logic [2:0] o_inflight;
    logic [1:0] o_state;

    int n_chk  = 0;
    int n_fail = 0;

    fp_pipe_ctrl dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_mode        (i_mode),
        .i_flush       (i_flush),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_stage_en    (o_stage_en),
        .o_stage_clr_n (o_stage_clr_n),
        .o_mode        (o_mode),
        .o_busy        (o_busy),
        .o_inflight    (o_inflight),
        .o_state       (o_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail < 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // slot[k] holds a tag for an operand sitting in stage k, 0 when empty.
    int slot[N];
    int mst     = 0;
    bit mmode   = 1'b0;
    int tagc    = 0;
    bit started = 1'b0;

    function automatic int m_count();
        int c = 0;
        for (int k = 0; k < N; k++) if (slot[k] != 0) c++;
        return c;
    endfunction

    // Stage k can load iff some stage at or after k is empty, or output drains.
    function automatic bit m_en(input int k);
        if (i_ready) return 1'b1;
        for (int j = k; j < N; j++) if (slot[j] == 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_ready();
        return !i_rst && m_en(0) && (mst == 0 || mst == 1) && !i_flush
               && (mst == 0 || i_mode == mmode);
    endfunction

    always @(posedge i_clk) begin
        bit acc;
        bit adv;
        if (i_rst) begin
            for (int k = 0; k < N; k++) slot[k] = 0;
            mst   = 0;
            mmode = 1'b0;
        end else begin
            acc = i_valid && m_ready();
            adv = (slot[N-1] != 0) && i_ready;
            if (i_flush) begin
                for (int k = 0; k < N; k++) slot[k] = 0;
                mst = 3;
            end else begin
                if (adv) slot[N-1] = 0;
                // Each operand moves forward one place if the place ahead is free.
                for (int k = N - 2; k >= 0; k--) begin
                    if (slot[k] != 0 && slot[k+1] == 0) begin
                        slot[k+1] = slot[k];
                        slot[k]   = 0;
                    end
                end
                if (acc) begin
                    if (slot[0] != 0) $display("FAIL model_insert: got stage0 busy expected empty");
                    tagc++;
                    slot[0] = tagc;
                end
                case (mst)
                    0: if (acc) begin mst = 1; mmode = i_mode; end
                    1: if (i_valid && i_mode != mmode) mst = 2;
                       else if (m_count() == 0) mst = 0;
                    2: if (m_count() == 0) mst = 0;
                    default: mst = 0;
                endcase
            end
        end
        started = 1'b1;
    end

    // Compare every cycle, sampled at the falling edge.
    always @(negedge i_clk) begin
        logic [4:0] een;
        if (started) begin
            for (int k = 0; k < N; k++) begin
                een[k] = !i_rst && m_en(k);
`ifdef FP_PIPE_BUBBLE_GATE_EN
                if (k == 0) een[k] = een[k] && i_valid && m_ready();
                else        een[k] = een[k] && (slot[k-1] != 0);
`endif
            end
            chk("o_ready",       32'(o_ready),       32'(m_ready()));
            chk("o_stage_en",    32'(o_stage_en),    32'(een));
            chk("o_stage_clr_n", 32'(o_stage_clr_n), (i_rst || mst == 3) ? 32'h0 : 32'h1f);
            chk("o_valid",       32'(o_valid),       32'(slot[N-1] != 0));
            chk("o_inflight",    32'(o_inflight),    32'(m_count()));
            chk("o_state",       32'(o_state),       32'(mst));
            chk("o_mode",        32'(o_mode),        32'(mmode));
            chk("o_busy",        32'(o_busy),        32'(mst != 0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic smp();
        @(negedge i_clk);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            cyc();
            smp();
            if (o_state == 2'd0 && o_inflight == 3'd0) ok = 1'b1;
        end
        chk("wait_idle_timeout", 32'(ok), 32'd1);
    endtask

    initial begin
        int nres;
        int first;
        int last;
        int peak;
        int nv;
        bit got;
        bit cur_mode;

        i_rst = 1'b1; i_valid = 1'b0; i_mode = 1'b0; i_flush = 1'b0; i_ready = 1'b1;

        // Reset values and outputs held low while in reset.
        cyc();
        smp();
        chk("rst_stage_en", 32'(o_stage_en),    32'h00);
        chk("rst_clr_n",    32'(o_stage_clr_n), 32'h00);
        chk("rst_ready",    32'(o_ready),       32'd0);
        chk("rst_state",    32'(o_state),       32'd0);
        chk("rst_inflight", 32'(o_inflight),    32'd0);

        // Single double-precision operand: result exactly 5 cycles later.
        cyc();
        i_rst = 1'b0; i_valid = 1'b1; i_mode = MODE_DP;
        smp();
        chk("single_ready", 32'(o_ready), 32'd1);
        cyc();
        i_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            smp();
            if (k < 5) chk("single_early_valid", 32'(o_valid), 32'd0);
            else begin
                chk("single_valid_t5", 32'(o_valid),    32'd1);
                chk("single_mode",     32'(o_mode),     32'd1);
                chk("single_inflight", 32'(o_inflight), 32'd1);
                chk("single_state",    32'(o_state),    32'd1);
            end
            cyc();
        end
        smp();
        chk("single_done_inflight", 32'(o_inflight), 32'd0);
        chk("single_done_state",    32'(o_state),    32'd0);

        // Eight back-to-back single-precision operands.
        nres = 0; first = -1; last = -1; peak = 0;
        for (int c = 0; c < 25; c++) begin
            cyc();
            i_valid = (c < 8);
            i_mode  = MODE_SP;
            smp();
            if (c < 8) chk("b2b_ready", 32'(o_ready), 32'd1);
            if (int'(o_inflight) > peak) peak = int'(o_inflight);
            if (o_valid && i_ready) begin
                nres++;
                if (first < 0) first = c;
                last = c;
            end
        end
        chk("b2b_results",    32'(nres),         32'd8);
        chk("b2b_contiguous", 32'(last - first), 32'd7);
        chk("b2b_peak",       32'(peak),         32'd5);

        // Fill with downstream stalled, hold 3 cycles, then release.
        i_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cyc();
            i_valid = 1'b1;
            smp();
        end
        for (int c = 0; c < 3; c++) begin
            cyc();
            smp();
            chk("stall_en",       32'(o_stage_en), 32'h00);
            chk("stall_ready",    32'(o_ready),    32'd0);
            chk("stall_inflight", 32'(o_inflight), 32'd5);
        end
        cyc();
        i_valid = 1'b0; i_ready = 1'b1;
        smp();
        chk("release_en", 32'(o_stage_en), 32'h1f);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) begin cyc(); smp(); end
            chk("release_valid", 32'(o_valid), 32'd1);
        end
        cyc();
        smp();
        chk("release_empty", 32'(o_valid), 32'd0);
        wait_idle();

        // Mode switch forces a drain before the new operand is taken.
        for (int c = 0; c < 3; c++) begin
            cyc();
            i_valid = 1'b1; i_mode = MODE_SP;
            smp();
        end
        cyc();
        i_mode = MODE_DP;
        smp();
        chk("drain_block", 32'(o_ready), 32'd0);
        cyc();
        smp();
        chk("drain_state", 32'(o_state), 32'd2);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (o_ready) got = 1'b1;
            else begin cyc(); smp(); end
        end
        chk("drain_timeout", 32'(got), 32'd1);
        chk("drain_exit_inflight", 32'(o_inflight), 32'd0);
        chk("drain_exit_state",    32'(o_state),    32'd0);
        cyc();
        i_valid = 1'b0;
        smp();
        chk("drain_new_mode",  32'(o_mode),  32'd1);
        chk("drain_new_state", 32'(o_state), 32'd1);
        wait_idle();

        // Flush with four in flight.
        for (int c = 0; c < 4; c++) begin
            cyc();
            i_valid = 1'b1; i_mode = MODE_DP;
            smp();
        end
        cyc();
        i_valid = 1'b0; i_flush = 1'b1;
        smp();
        chk("flush_pre_inflight", 32'(o_inflight), 32'd4);
        cyc();
        i_flush = 1'b0;
        smp();
        chk("flush_clr_n", 32'(o_stage_clr_n), 32'h00);
        chk("flush_state", 32'(o_state),       32'd3);
        chk("flush_valid", 32'(o_valid),       32'd0);
        cyc();
        smp();
        chk("flush_after_state",    32'(o_state),    32'd0);
        chk("flush_after_inflight", 32'(o_inflight), 32'd0);
        chk("flush_mode_kept",      32'(o_mode),     32'd1);
        nv = 0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            smp();
            if (o_valid) nv++;
        end
        chk("flush_leak", 32'(nv), 32'd0);

        // Reset in the middle of a stream.
        for (int c = 0; c < 3; c++) begin
            cyc();
            i_valid = 1'b1; i_mode = MODE_DP;
            smp();
        end
        cyc();
        i_valid = 1'b0; i_rst = 1'b1;
        smp();
        chk("midrst_inflight", 32'(o_inflight),    32'd3);
        chk("midrst_clr_n",    32'(o_stage_clr_n), 32'h00);
        chk("midrst_en",       32'(o_stage_en),    32'h00);
        chk("midrst_ready",    32'(o_ready),       32'd0);
        cyc();
        i_rst = 1'b0;
        smp();
        chk("midrst_state",    32'(o_state),       32'd0);
        chk("midrst_zero",     32'(o_inflight),    32'd0);
        chk("midrst_valid",    32'(o_valid),       32'd0);
        chk("midrst_mode",     32'(o_mode),        32'd0);
        chk("midrst_busy",     32'(o_busy),        32'd0);
        chk("midrst_clr_rel",  32'(o_stage_clr_n), 32'h1f);

        // Randomized traffic against the model.
        cur_mode = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            cyc();
            if ($urandom_range(99) < 8) cur_mode = ~cur_mode;
            i_valid = ($urandom_range(99) < 70);
            i_mode  = cur_mode;
            i_ready = ($urandom_range(99) < 60);
            i_flush = ($urandom_range(999) < 20);
            i_rst   = ($urandom_range(999) < 5);
        end
        cyc();
        i_valid = 1'b0; i_flush = 1'b0; i_rst = 1'b0; i_ready = 1'b1;
        smp();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
